issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Register-hazard controller between the decoder and the register-file read/issue point.
- Tracks the in-flight writes to each architectural register, with a small counter per register.
- Stalls decode while any source or destination hazard is unresolved.
- Accepts writeback retirements and squash (kill) notifications from later pipeline stages.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (maximum in-flight writes per register is 2**CNT_W-1).
- WB_BYPASS, 1, when 1, a same-cycle writeback to a source register clears that source's hazard for the cycle.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, asynchronous, active-low.
- dec_valid_i  input  1  the decoded instruction is present.
- dec_rs1_i  input  5  source register 1 index.
- dec_rs2_i  input  5  source register 2 index.
- dec_rd_i  input  5  destination register index.
- dec_use_rs1_i  input  1  the instruction reads rs1.
- dec_use_rs2_i  input  1  the instruction reads rs2.
- dec_wr_rd_i  input  1  the instruction writes rd.
- wb_valid_i  input  1  writeback retires a write this cycle.
- wb_rd_i  input  5  destination register of that writeback.
- kill_valid_i  input  1  a previously issued writing instruction was squashed.
- kill_rd_i  input  5  destination register of the squashed instruction.
- stall_o  output  1  hold decode; the instruction is not issued.
- issue_o  output  1  the instruction issues this cycle; equals dec_valid_i & ~stall_o.
- busy_o  output  32  per-register "pending count nonzero"; bit 0 is always 0.
- err_o  output  1  sticky error flag for counter underflow.

Behaviour:
- State:
  - cnt[1..31], each CNT_W bits wide.
  - err flag.
  - x0 is never tracked: cnt[0] does not exist, and any issue, writeback or kill naming x0 is ignored.
- Reset (rst=0, asynchronous):
  - All cnt are 0 and err is 0.
  - Outputs are therefore busy_o=0 and err_o=0.
  - stall_o=0 and issue_o=dec_valid_i while reset is held.
  - Counter updates are blocked during reset.
  - Reset asserted mid-operation discards all pending state; no drain occurs.
- Hazard terms (combinational, same cycle):
  - raw1 = dec_use_rs1_i & rs1!=0 & cnt[rs1]!=0 & ~(WB_BYPASS & wb_valid_i & wb_rd_i==rs1 & cnt[rs1]==1).
  - raw2 is the same term for rs2.
  - waw_full = dec_wr_rd_i & rd!=0 & cnt[rd]==max & ~(wb_valid_i & wb_rd_i==rd). This is a structural stall on counter saturation.
  - stall_o = dec_valid_i & (raw1 | raw2 | waw_full | err).
  - A set err stalls all issue until reset.
- Counter update (clocked, rising edge):
  - For each register r, the next count is cnt[r] + inc - dec_wb - dec_kill.
    - inc = issue_o & dec_wr_rd_i & rd==r.
    - dec_wb = wb_valid_i & wb_rd_i==r.
    - dec_kill = kill_valid_i & kill_rd_i==r.
  - Net change per cycle lies in -2..+1.
  - Compute in CNT_W+2 signed bits and truncate after the checks below.
- Simultaneous events:
  - Issue, writeback and kill to the same register in one cycle all apply: net -1.
  - Issue and writeback to the same register net to 0.
  - Writeback and kill to the same register in one cycle is legal only when cnt>=2.
- Underflow:
  - Occurs when the net result would be negative.
  - The counter is held at 0 and err is set (sticky).
- Overflow:
  - Cannot occur, because waw_full blocks the issue.
  - An assertion checks the result never exceeds max.
- Latency:
  - An issue makes busy_o visible on the next cycle.
  - A writeback or kill clears a hazard on the next cycle.
  - With WB_BYPASS=1, a writeback also clears a RAW hazard in the same cycle.
- busy_o[r] = (cnt[r]!=0), registered state only.
- There is no state machine beyond the counters; stall_o is purely combinational from state and inputs.

Decomposition:
- core package:
  - typedef reg_idx_t (5 bits).
  - localparam NUM_ARCH_REGS=32.
  - typedef sb_cnt_t, parameterised by CNT_W through the module.
- Sub-module sb_counter:
  - One per register, instantiated with generate for r=1..31.
  - Inputs: inc, dec_wb, dec_kill.
  - Outputs: cnt, nonzero, is_one, is_max, underflow.
- The top level ORs the underflow outputs into err and muxes cnt by rs1, rs2 and rd.

Test Plan:
- RAW then release:
  - Issue rd=x5 (wr=1): issue_o=1, busy_o[5]=1 next cycle.
  - Next, use_rs1=1, rs1=x5: stall_o=1.
  - wb x5 in the same cycle with WB_BYPASS=1: stall_o=0 and issue_o=1 that cycle.
  - With WB_BYPASS=0: stall_o=1, and the instruction issues the following cycle.
- x0 ignored: issue rd=x0, then rs1=x0, rs2=x0 -> stall_o=0 throughout; busy_o=0.
- Saturation (CNT_W=2):
  - Three issues to x7 give cnt=3.
  - A fourth write to x7: stall_o=1.
  - Same cycle with wb x7: issues, cnt stays 3.
- Simultaneous events:
  - cnt[x9]=2.
  - Same cycle: issue x9, wb x9, kill x9 -> cnt[x9]=1 next cycle, busy_o[9]=1, err_o=0.
- Underflow:
  - wb x3 with cnt[x3]=0 -> err_o=1 next cycle, cnt stays 0.
  - Subsequent dec_valid_i=1: stall_o=1.
  - Reset clears err_o to 0.
- Mid-operation reset:
  - Several registers busy.
  - Assert rst=0 asynchronously between edges: busy_o=0 immediately.
  - After release, rs1 of a previously busy register: stall_o=0.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_pkg
// Shared types and helpers for the register-hazard scoreboard.
//   reg_idx_t     : architectural register index (x0..x31)
//   NUM_ARCH_REGS : number of architectural registers
//   reg_decode    : one-hot decode of a register index over x1..x31
// -----------------------------------------------------------------------------
package issue_scoreboard_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned REG_IDX_W     = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // x0 has no slot in the result, so any event naming x0 decodes to nothing.
    function automatic logic [NUM_ARCH_REGS-1:1] reg_decode(input reg_idx_t idx,
                                                            input logic     en);
        logic [NUM_ARCH_REGS-1:1] hit;
        hit = '0;
        for (int unsigned r = 1; r < NUM_ARCH_REGS; r++) begin
            hit[r] = en && (idx == reg_idx_t'(r));
        end
        return hit;
    endfunction

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// Pending-write counter for one architectural register.
//   clk, rst     : core clock, asynchronous active-low reset
//   inc_i        : a write to this register issues this cycle
//   dec_wb_i     : a write to this register retires this cycle
//   dec_kill_i   : a write to this register is squashed this cycle
//   cnt_o        : current pending count
//   nonzero_o    : count != 0
//   is_one_o     : count == 1
//   is_max_o     : count == 2**CNT_W-1
//   underflow_o  : this cycle's update would go negative (count held at 0)
// -----------------------------------------------------------------------------
module sb_counter
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_wb_i,
    input  logic             dec_kill_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nonzero_o,
    output logic             is_one_o,
    output logic             is_max_o,
    output logic             underflow_o
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_S = $signed({2'b00, {CNT_W{1'b1}}});

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0] sum_s;

    // Two guard bits cover the full -2..+1 net swing before truncation.
    always_comb begin
        sum_s = $signed({2'b00, cnt_q})
              + $signed(SUM_W'(inc_i))
              - $signed(SUM_W'(dec_wb_i))
              - $signed(SUM_W'(dec_kill_i));
        underflow_o = sum_s[SUM_W-1];
        cnt_d       = underflow_o ? '0 : sum_s[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturation stalls issue upstream, so the sum can never pass max.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (sum_s <= MAX_S);
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = |cnt_q;
    assign is_one_o  = (cnt_q == CNT_W'(1));
    assign is_max_o  = &cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// Register-hazard controller between decode and register-file read/issue.
//   clk, rst                 : core clock, asynchronous active-low reset
//   dec_valid_i              : decoded instruction present
//   dec_rs1_i/dec_rs2_i      : source indices, qualified by dec_use_rs*_i
//   dec_rd_i                 : destination index, qualified by dec_wr_rd_i
//   wb_valid_i/wb_rd_i       : writeback retirement
//   kill_valid_i/kill_rd_i   : squash of a previously issued write
//   stall_o                  : hold decode
//   issue_o                  : dec_valid_i & ~stall_o
//   busy_o                   : per-register pending count nonzero (bit 0 = 0)
//   err_o                    : sticky counter-underflow flag
// -----------------------------------------------------------------------------
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid_i,
    input  reg_idx_t                 dec_rs1_i,
    input  reg_idx_t                 dec_rs2_i,
    input  reg_idx_t                 dec_rd_i,
    input  logic                     dec_use_rs1_i,
    input  logic                     dec_use_rs2_i,
    input  logic                     dec_wr_rd_i,
    input  logic                     wb_valid_i,
    input  reg_idx_t                 wb_rd_i,
    input  logic                     kill_valid_i,
    input  reg_idx_t                 kill_rd_i,
    output logic                     stall_o,
    output logic                     issue_o,
    output logic [NUM_ARCH_REGS-1:0] busy_o,
    output logic                     err_o
);

    typedef logic [CNT_W-1:0] sb_cnt_t;

    logic [NUM_ARCH_REGS-1:1] inc_vec, wb_vec, kill_vec;
    logic [NUM_ARCH_REGS-1:1] nz_vec, one_vec, max_vec, uf_vec;
    logic [NUM_ARCH_REGS-1:0] one_full, max_full;
    sb_cnt_t                  cnt_arr [NUM_ARCH_REGS];

    logic err_q, err_d;
    logic raw1, raw2, waw_full;

    assign cnt_arr[0] = '0;
    assign one_full   = {one_vec, 1'b0};
    assign max_full   = {max_vec, 1'b0};

    for (genvar r = 1; r < NUM_ARCH_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_vec[r]),
            .dec_wb_i    (wb_vec[r]),
            .dec_kill_i  (kill_vec[r]),
            .cnt_o       (cnt_arr[r]),
            .nonzero_o   (nz_vec[r]),
            .is_one_o    (one_vec[r]),
            .is_max_o    (max_vec[r]),
            .underflow_o (uf_vec[r])
        );
    end

    // A retiring last write to a source clears its RAW hazard in the same cycle.
    always_comb begin
        raw1 = dec_use_rs1_i && (dec_rs1_i != '0) && (cnt_arr[dec_rs1_i] != '0)
            && !(WB_BYPASS && wb_valid_i && (wb_rd_i == dec_rs1_i) && one_full[dec_rs1_i]);
        raw2 = dec_use_rs2_i && (dec_rs2_i != '0) && (cnt_arr[dec_rs2_i] != '0)
            && !(WB_BYPASS && wb_valid_i && (wb_rd_i == dec_rs2_i) && one_full[dec_rs2_i]);
        // A saturated counter may still take a new write if one retires this cycle.
        waw_full = dec_wr_rd_i && (dec_rd_i != '0) && (cnt_arr[dec_rd_i] == '1)
            && max_full[dec_rd_i] && !(wb_valid_i && (wb_rd_i == dec_rd_i));
        stall_o = dec_valid_i && (raw1 || raw2 || waw_full || err_q);
        issue_o = dec_valid_i && !stall_o;
    end

    assign inc_vec  = reg_decode(dec_rd_i, issue_o && dec_wr_rd_i);
    assign wb_vec   = reg_decode(wb_rd_i, wb_valid_i);
    assign kill_vec = reg_decode(kill_rd_i, kill_valid_i);

    assign err_d = err_q || (|uf_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busy_o = {nz_vec, 1'b0};
    assign err_o  = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       dv, u1, u2, wr, wbv, kv;
    logic [4:0] rs1, rs2, rd, wbrd, krd;

    // index 0: WB_BYPASS=1, index 1: WB_BYPASS=0
    logic        stall_w [2];
    logic        issue_w [2];
    logic        err_w   [2];
    logic [31:0] busy_w  [2];
    bit          byp     [2] = '{1'b1, 1'b0};

    int vec    = 0;
    int miscmp = 0;

    // Behavioural model: pending counts as plain integers per DUT.
    int cnt_m   [2][32];
    bit err_m   [2];
    int nxt_cnt [2][32];
    bit nxt_err [2];

    always #5 clk = ~clk;

    issue_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .dec_valid_i(dv), .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rd_i(rd),
        .dec_use_rs1_i(u1), .dec_use_rs2_i(u2), .dec_wr_rd_i(wr),
        .wb_valid_i(wbv), .wb_rd_i(wbrd), .kill_valid_i(kv), .kill_rd_i(krd),
        .stall_o(stall_w[0]), .issue_o(issue_w[0]), .busy_o(busy_w[0]), .err_o(err_w[0])
    );

    issue_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .dec_valid_i(dv), .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rd_i(rd),
        .dec_use_rs1_i(u1), .dec_use_rs2_i(u2), .dec_wr_rd_i(wr),
        .wb_valid_i(wbv), .wb_rd_i(wbrd), .kill_valid_i(kv), .kill_rd_i(krd),
        .stall_o(stall_w[1]), .issue_o(issue_w[1]), .busy_o(busy_w[1]), .err_o(err_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, and next-state prediction.
    always @(negedge clk) begin
        bit          h1, h2, wf, es, ei, ne;
        logic [31:0] eb;
        int          n;
        for (int b = 0; b < 2; b++) begin
            h1 = u1 && rs1 != 0 && cnt_m[b][rs1] > 0
                 && !(byp[b] && wbv && wbrd == rs1 && cnt_m[b][rs1] == 1);
            h2 = u2 && rs2 != 0 && cnt_m[b][rs2] > 0
                 && !(byp[b] && wbv && wbrd == rs2 && cnt_m[b][rs2] == 1);
            wf = wr && rd != 0 && cnt_m[b][rd] == MAXC && !(wbv && wbrd == rd);
            es = dv && (h1 || h2 || wf || err_m[b]);
            ei = dv && !es;
            eb = '0;
            for (int r = 1; r < 32; r++) eb[r] = (cnt_m[b][r] != 0);
            chk($sformatf("stall[byp=%0d]", byp[b]), 32'(stall_w[b]), 32'(es));
            chk($sformatf("issue[byp=%0d]", byp[b]), 32'(issue_w[b]), 32'(ei));
            chk($sformatf("busy[byp=%0d]", byp[b]), busy_w[b], eb);
            chk($sformatf("err[byp=%0d]", byp[b]), 32'(err_w[b]), 32'(err_m[b]));
            ne = err_m[b];
            for (int r = 1; r < 32; r++) begin
                n = cnt_m[b][r];
                if (ei && wr && rd == r) n = n + 1;
                if (wbv && wbrd == r)    n = n - 1;
                if (kv && krd == r)      n = n - 1;
                if (n < 0) begin
                    n  = 0;
                    ne = 1'b1;
                end
                nxt_cnt[b][r] = rst ? n : 0;
            end
            nxt_err[b] = rst ? ne : 1'b0;
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 32; r++) cnt_m[b][r] = rst ? nxt_cnt[b][r] : 0;
            err_m[b] = rst ? nxt_err[b] : 1'b0;
        end
    end

    task automatic clr();
        dv = 0; u1 = 0; u2 = 0; wr = 0; wbv = 0; kv = 0;
        rs1 = 0; rs2 = 0; rd = 0; wbrd = 0; krd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        // reset held: pass-through issue, everything clear
        #1 dv = 1;
        #1;
        chk("rst_issue_b", 32'(issue_w[0]), 1);
        chk("rst_stall_n", 32'(stall_w[1]), 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_err", 32'(err_w[1]), 0);
        tick(); tick();
        rst = 1;
        clr();

        // RAW then release
        dv = 1; wr = 1; rd = 5;
        #1 chk("raw_issue_wr", 32'(issue_w[0]), 1);
        tick();
        clr(); dv = 1; u1 = 1; rs1 = 5;
        #1;
        chk("raw_busy5", busy_w[0] & 32'h20, 32'h20);
        chk("raw_stall_b", 32'(stall_w[0]), 1);
        chk("raw_stall_n", 32'(stall_w[1]), 1);
        wbv = 1; wbrd = 5;
        #1;
        chk("byp_stall_b", 32'(stall_w[0]), 0);
        chk("byp_issue_b", 32'(issue_w[0]), 1);
        chk("nobyp_stall_n", 32'(stall_w[1]), 1);
        tick();
        wbv = 0;
        #1;
        chk("nobyp_issue_next", 32'(issue_w[1]), 1);
        chk("raw_released", busy_w[1] & 32'h20, 0);
        tick();

        // x0 never tracked
        clr(); dv = 1; wr = 1; rd = 0;
        #1 chk("x0_issue", 32'(issue_w[0]), 1);
        tick();
        clr(); dv = 1; u1 = 1; u2 = 1;
        #1;
        chk("x0_stall", 32'(stall_w[0]), 0);
        chk("x0_busy", busy_w[0], 0);
        tick();

        // saturation at 3 pending writes
        for (int i = 0; i < 3; i++) begin
            clr(); dv = 1; wr = 1; rd = 7;
            #1 chk("sat_fill_issue", 32'(issue_w[0]), 1);
            tick();
        end
        #1;
        chk("model_cnt7_full", 32'(cnt_m[0][7]), 3);
        chk("sat_stall", 32'(stall_w[0]), 1);
        wbv = 1; wbrd = 7;
        #1;
        chk("sat_wb_issue", 32'(issue_w[1]), 1);
        tick();
        wbv = 0;
        #1;
        chk("sat_still_full", 32'(stall_w[0]), 1);
        chk("model_cnt7_hold", 32'(cnt_m[1][7]), 3);
        clr(); wbv = 1; wbrd = 7;
        tick(); tick(); tick();
        clr();
        #1 chk("sat_drained", busy_w[0] & 32'h80, 0);

        // issue + wb + kill to one register: net -1
        dv = 1; wr = 1; rd = 9;
        tick(); tick();
        wbv = 1; wbrd = 9; kv = 1; krd = 9;
        #1 chk("sim_issue", 32'(issue_w[0]), 1);
        tick();
        clr();
        #1;
        chk("sim_busy9", busy_w[0] & 32'h200, 32'h200);
        chk("sim_err", 32'(err_w[0]), 0);
        chk("model_cnt9", 32'(cnt_m[0][9]), 1);
        wbv = 1; wbrd = 9;
        tick();
        clr();

        // asynchronous reset mid-operation
        dv = 1; wr = 1; rd = 10; tick();
        rd = 11; tick();
        rd = 12; tick();
        clr();
        #1 chk("mid_busy", busy_w[0] & 32'h1C00, 32'h1C00);
        #1 rst = 0;
        #1;
        chk("mid_rst_busy_b", busy_w[0], 0);
        chk("mid_rst_busy_n", busy_w[1], 0);
        tick();
        rst = 1;
        dv = 1; u1 = 1; rs1 = 10;
        #1 chk("mid_post_stall", 32'(stall_w[0]), 0);
        tick();
        clr();

        // underflow: sticky err blocks issue until reset
        wbv = 1; wbrd = 3;
        tick();
        clr();
        #1;
        chk("uf_err_b", 32'(err_w[0]), 1);
        chk("uf_err_n", 32'(err_w[1]), 1);
        chk("uf_busy", busy_w[0], 0);
        dv = 1;
        #1 chk("uf_stall", 32'(stall_w[0]), 1);
        tick();
        rst = 0;
        #1 chk("uf_rst_clear", 32'(err_w[0]), 0);
        tick();
        rst = 1;
        #1 chk("uf_post_rst_issue", 32'(issue_w[1]), 1);
        tick(); tick();
        clr();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
